// File: rtl/ikaopll_eg_pkg.sv
// Shared types and constants for the EG attenuation stage: slot state encoding,
// per-slot shift-register payload and rate thresholds.
package ikaopll_eg_pkg;

    localparam int unsigned SLOTS   = 18;
    localparam int unsigned ATTEN_W = 7;
    localparam int unsigned RATE_W  = 4;

    localparam logic [ATTEN_W-1:0] ATTEN_MAX       = 7'd127;
    localparam logic [3:0]         RATE_HI_FAST    = 4'd12;
    localparam logic [3:0]         RATE_HI_INSTANT = 4'd15;

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } eg_state_e;

    // One slot's circulating context.
    typedef struct packed {
        logic               kon_z;
        eg_state_e          state;
        logic [ATTEN_W-1:0] atten;
    } eg_slot_t;

    localparam eg_slot_t SLOT_RESET = '{kon_z: 1'b0, state: ST_RELEASE, atten: ATTEN_MAX};

endpackage

// File: rtl/ikaopll_eg_stepcalc.sv
// Effective EG rate (rate*4 + key-scale offset, clamped) and the attenuation
// increment it yields for the current envelope-counter phase.
module ikaopll_eg_stepcalc
    import ikaopll_eg_pkg::*;
(
    input  logic [RATE_W-1:0] rate_i,
    input  logic [3:0]        ksroffs_i,
    input  logic [1:0]        envcntr_i,
    input  logic [3:0]        conseczb_i,
    output logic [3:0]        rate_hi_o,
    output logic [2:0]        inc_o
);

    logic [6:0] rate_sum;
    logic [5:0] eff_rate;
    logic [1:0] rate_lo;
    logic [4:0] zb_sum;

    always_comb begin
        rate_sum = 7'({rate_i, 2'b00}) + 7'(ksroffs_i);
        if (rate_i == '0) begin
            eff_rate = '0;
        end else if (rate_sum > 7'd63) begin
            eff_rate = 6'd63;
        end else begin
            eff_rate = rate_sum[5:0];
        end
        rate_hi_o = eff_rate[5:2];
        rate_lo   = eff_rate[1:0];
        zb_sum    = 5'(eff_rate[5:2]) + 5'(conseczb_i);

        // Slow rates tick on a subset of counter phases; fast rates step every visit.
        inc_o = '0;
        if (eff_rate == '0) begin
            inc_o = '0;
        end else if (eff_rate[5:2] < RATE_HI_FAST) begin
            inc_o = (zb_sum >= 5'(RATE_HI_FAST) && rate_lo >= envcntr_i) ? 3'd1 : 3'd0;
        end else begin
            inc_o = 3'(eff_rate[5:2] - (RATE_HI_FAST - 4'd1));
        end
    end

endmodule

// File: rtl/ikaopll_eg_attenuator.sv
// Per-slot EG state machine and 7-bit attenuation, with 18 slot contexts
// circulating through a shift register advanced on the phi1 negative enable.
module ikaopll_eg_attenuator
    import ikaopll_eg_pkg::*;
(
    input  logic               i_EMUCLK,
    input  logic               i_IC_n,
    input  logic               i_phi1_PCEN_n,
    input  logic               i_phi1_NCEN_n,
    input  logic               i_CYCLE_00,
    input  logic               i_KON,
    input  logic [3:0]         i_SL,
    input  logic [RATE_W-1:0]  i_RATE,
    input  logic [3:0]         i_KSROFFS,
    input  logic [1:0]         i_ENVCNTR,
    input  logic [3:0]         i_CONSECZB,
    output logic [1:0]         o_ENVSTAT,
    output logic [ATTEN_W-1:0] o_EG_ATTEN
);

    eg_slot_t           sr_q [SLOTS];
    eg_slot_t           head;
    eg_slot_t           slot_d;
    logic               aligned_q;
    logic               aligned_d;
    logic [3:0]         rate_hi;
    logic [2:0]         inc;
    logic [7:0]         rise_sum;
    logic [ATTEN_W-1:0] atten_inc;
    logic [ATTEN_W-1:0] atk_shift;
    logic [7:0]         atk_sub;
    logic [ATTEN_W-1:0] atten_atk;
    logic               unused_pcen;

    assign unused_pcen = i_phi1_PCEN_n;
    assign head        = sr_q[0];
    assign o_ENVSTAT   = head.state;
    assign o_EG_ATTEN  = head.atten;

    ikaopll_eg_stepcalc u_stepcalc (
        .rate_i     (i_RATE),
        .ksroffs_i  (i_KSROFFS),
        .envcntr_i  (i_ENVCNTR),
        .conseczb_i (i_CONSECZB),
        .rate_hi_o  (rate_hi),
        .inc_o      (inc)
    );

    // Next context for the head slot; key edges override rate stepping.
    always_comb begin
        aligned_d = aligned_q | i_CYCLE_00;

        rise_sum  = {1'b0, head.atten} + 8'(inc);
        atten_inc = rise_sum[7] ? ATTEN_MAX : rise_sum[6:0];
        atk_shift = head.atten >> (3'd5 - inc);
        atk_sub   = {1'b0, atk_shift} + 8'd1;
        atten_atk = (atk_sub >= {1'b0, head.atten}) ? '0 : 7'({1'b0, head.atten} - atk_sub);

        slot_d       = head;
        slot_d.kon_z = i_KON;

        if (!aligned_d) begin
            // Until the frame start is seen after reset, contexts only rotate.
            slot_d = head;
        end else if (!head.kon_z && i_KON) begin
            slot_d.state = ST_ATTACK;
            if (rate_hi == RATE_HI_INSTANT) begin
                slot_d.atten = '0;
            end
        end else if (head.kon_z && !i_KON) begin
            slot_d.state = ST_RELEASE;
        end else begin
            case (head.state)
                ST_ATTACK: begin
                    if (head.atten == '0) begin
                        slot_d.state = ST_DECAY;
                    end else if (rate_hi == RATE_HI_INSTANT) begin
                        slot_d.atten = '0;
                    end else if (inc != '0) begin
                        slot_d.atten = atten_atk;
                    end
                end
                ST_DECAY: begin
                    if (head.atten[6:3] >= i_SL) begin
                        slot_d.state = ST_SUSTAIN;
                    end else begin
                        slot_d.atten = atten_inc;
                    end
                end
                default: slot_d.atten = atten_inc;
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            aligned_q <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                sr_q[i] <= SLOT_RESET;
            end
        end else if (!i_phi1_NCEN_n) begin
            aligned_q <= aligned_d;
            for (int unsigned i = 0; i < SLOTS - 1; i++) begin
                sr_q[i] <= sr_q[i+1];
            end
            sr_q[SLOTS-1] <= slot_d;
        end
    end

endmodule
